// File: rtl/operand_fetch.sv
// operand_fetch
//   Decode-stage operand reader. Drives the register file's two asynchronous
//   read ports, picks each source operand from x0, same-cycle writeback data
//   or register file data, and captures the result into an ID/EX register.
//   A busy bit per register tracks in-flight destinations. Issue stalls on
//   RAW and WAW hazards against those bits.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           upstream (decode) handshake
//   in_rs1, in_rs2                source register indices
//   in_rs1_en, in_rs2_en          source read enables
//   in_rd, in_rd_we               destination index and write enable
//   rf_a1, rf_a2                  register file read addresses
//   rf_rd1, rf_rd2                register file read data
//   wb_valid, wb_rd, wb_data      writeback commit
//   flush                         kill the entry held in the output register
//   out_valid / out_ready         downstream (execute) handshake
//   out_rs1_data, out_rs2_data    registered operands
//   out_rd, out_rd_we             registered destination

module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic            in_rs1_en,
  input  logic            in_rs2_en,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  output logic [AW-1:0]   rf_a1,
  output logic [AW-1:0]   rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wbClr;
  logic [NREG-1:0] effBusy;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] opA, opB;

  logic            out_valid_q;
  logic [XLEN-1:0] out_rs1_q, out_rs2_q;
  logic [AW-1:0]   out_rd_q;
  logic            out_rd_we_q;

  assign rf_a1 = in_rs1;
  assign rf_a2 = in_rs2;

  // A writeback this cycle retires its register immediately, so the busy
  // view used for hazards already has that bit dropped. x0 never counts.
  always_comb begin
    wbClr = '0;
    if (wb_valid && (wb_rd != '0))
      wbClr[wb_rd] = 1'b1;
    effBusy = busy_q & ~wbClr;
    effBusy[0] = 1'b0;
  end

  // Stall on any enabled source or destination that is still in flight,
  // on a full output register that is not draining, and during a flush.
  always_comb begin
    hazard   = (in_rs1_en && effBusy[in_rs1]) ||
               (in_rs2_en && effBusy[in_rs2]) ||
               (in_rd_we  && effBusy[in_rd]);
    in_ready = !flush && !hazard && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  // Operand select: x0 reads zero, a same-cycle writeback to the index
  // bypasses the register file (whose write edge may not have happened yet).
  always_comb begin
    if (in_rs1 == '0)
      opA = '0;
    else if (wbClr[in_rs1])
      opA = wb_data;
    else
      opA = rf_rd1;

    if (in_rs2 == '0)
      opB = '0;
    else if (wbClr[in_rs2])
      opB = wb_data;
    else
      opB = rf_rd2;
  end

  // Scoreboard next state. Later assignments override earlier ones, so a
  // new issue to a register wins over a writeback or flush clearing it.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid)
      busy_d[wb_rd] = 1'b0;
    if (flush && out_valid_q && out_rd_we_q)
      busy_d[out_rd_q] = 1'b0;
    if (accept && in_rd_we && (in_rd != '0))
      busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  // ID/EX register. Flush empties it; an accept loads it; a drain without
  // a new accept empties it; otherwise every field holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_rs1_q   <= opA;
      out_rs2_q   <= opB;
      out_rd_q    <= in_rd;
      out_rd_we_q <= in_rd_we;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rs1_data = out_rs1_q;
  assign out_rs2_data = out_rs2_q;
  assign out_rd       = out_rd_q;
  assign out_rd_we    = out_rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//   Directed bench for operand_fetch. Each scenario task drives its own
//   vectors and compares against hand-computed values.

module tb_operand_fetch;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rs1, in_rs2, in_rd;
  logic            in_rs1_en, in_rs2_en, in_rd_we;
  logic [AW-1:0]   rf_a1, rf_a2;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1_data, out_rs2_data;
  logic [AW-1:0]   out_rd;
  logic            out_rd_we;

  int nCompared;
  int nMismatched;

  operand_fetch #(.XLEN(XLEN), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rs1_en    (in_rs1_en),
    .in_rs2_en    (in_rs2_en),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .rf_a1        (rf_a1),
    .rf_a2        (rf_a2),
    .rf_rd1       (rf_rd1),
    .rf_rd2       (rf_rd2),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rd       (out_rd),
    .out_rd_we    (out_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rs1_en = 1'b0;
    in_rs2_en = 1'b0;
    in_rd     = '0;
    in_rd_we  = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic present(input logic [AW-1:0] rs1, input logic e1,
                         input logic [AW-1:0] rs2, input logic e2,
                         input logic [AW-1:0] rd, input logic we);
    in_valid  = 1'b1;
    in_rs1    = rs1;
    in_rs1_en = e1;
    in_rs2    = rs2;
    in_rs2_en = e2;
    in_rd     = rd;
    in_rd_we  = we;
  endtask

  task automatic test_reset();
    idle();
    rf_rd1 = '0;
    rf_rd2 = '0;
    rst_n  = 1'b0;
    #12;
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid);
    end
    nCompared++;
    if ({out_rs1_data, out_rs2_data, out_rd, out_rd_we} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_fields got %h %h %h %b exp zeros",
               out_rs1_data, out_rs2_data, out_rd, out_rd_we);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_issue();
    rf_rd1 = 32'h11;
    rf_rd2 = 32'h22;
    present(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0);
    #1;
    nCompared++;
    if (rf_a1 !== 5'd1 || rf_a2 !== 5'd2) begin
      nMismatched++;
      $display("[TB] FAIL basic_addr got %0d %0d exp 1 2", rf_a1, rf_a2);
    end
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL basic_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    nCompared++;
    if (out_valid !== 1'b1 || out_rs1_data !== 32'h11 || out_rs2_data !== 32'h22) begin
      nMismatched++;
      $display("[TB] FAIL basic_ops got v=%b %h %h exp v=1 11 22",
               out_valid, out_rs1_data, out_rs2_data);
    end
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL basic_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_raw_stall();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    tick();
    rf_rd1 = 32'hDEAD;
    present(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0);
    #1;
    nCompared++;
    if (in_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL raw_stall got %b exp 0", in_ready);
    end
    tick();
    nCompared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL raw_stall_hold got ready=%b valid=%b exp 0 0", in_ready, out_valid);
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'hABCD;
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL raw_wb_release got %b exp 1", in_ready);
    end
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b0;
    nCompared++;
    if (out_valid !== 1'b1 || out_rs1_data !== 32'hABCD) begin
      nMismatched++;
      $display("[TB] FAIL raw_forward got v=%b %h exp v=1 0000abcd", out_valid, out_rs1_data);
    end
    tick();
  endtask

  task automatic test_x0();
    rf_rd1 = 32'hFFFFFFFF;
    rf_rd2 = 32'hFFFFFFFF;
    present(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    tick();
    nCompared++;
    if (out_valid !== 1'b1 || out_rs1_data !== '0 || out_rs2_data !== '0 ||
        out_rd !== 5'd0 || out_rd_we !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL x0_ops got v=%b %h %h rd=%0d we=%b exp v=1 0 0 rd=0 we=1",
               out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_we);
    end
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL x0_no_stall got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    rf_rd1 = 32'h100;
    present(5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0);
    tick();
    rf_rd1 = 32'h200;
    present(5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      nCompared++;
      if (in_ready !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL bp_ready cycle %0d got %b exp 0", i, in_ready);
      end
      tick();
      nCompared++;
      if (out_valid !== 1'b1 || out_rs1_data !== 32'h100 || out_rd !== 5'd10) begin
        nMismatched++;
        $display("[TB] FAIL bp_hold cycle %0d got v=%b %h rd=%0d exp v=1 100 rd=10",
                 i, out_valid, out_rs1_data, out_rd);
      end
    end
    out_ready = 1'b1;
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL bp_release got %b exp 1", in_ready);
    end
    tick();
    nCompared++;
    if (out_rs1_data !== 32'h200 || out_rd !== 5'd11) begin
      nMismatched++;
      $display("[TB] FAIL bp_second got %h rd=%0d exp 200 rd=11", out_rs1_data, out_rd);
    end
    rf_rd1 = 32'h300;
    present(5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b0);
    tick();
    nCompared++;
    if (out_valid !== 1'b1 || out_rs1_data !== 32'h300) begin
      nMismatched++;
      $display("[TB] FAIL bp_back_to_back got v=%b %h exp v=1 300", out_valid, out_rs1_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b0);
    flush = 1'b1;
    #1;
    nCompared++;
    if (in_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL flush_ready got %b exp 0", in_ready);
    end
    tick();
    flush = 1'b0;
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL flush_valid got %b exp 0", out_valid);
    end
    present(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL flush_busy_clear got %b exp 1", in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_waw_same_cycle();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    wb_data  = 32'h99;
    #1;
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL waw_accept got %b exp 1", in_ready);
    end
    tick();
    wb_valid = 1'b0;
    present(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    nCompared++;
    if (in_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL waw_set_wins got %b exp 0", in_ready);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    nCompared++;
    if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_rd_we !== 1'b0 ||
        out_rs1_data !== '0 || out_rs2_data !== '0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset_out got v=%b rd=%0d we=%b %h %h exp zeros",
               out_valid, out_rd, out_rd_we, out_rs1_data, out_rs2_data);
    end
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL async_reset_busy got %b exp 1", in_ready);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    $display("[TB] operand_fetch directed tests");
    test_reset();
    test_basic_issue();
    test_raw_stall();
    test_x0();
    test_backpressure();
    test_flush();
    test_waw_same_cycle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
